// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states, op classification.
// Latency: n/a (package).
// Backpressure: n/a (package).
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NAND = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd8;
  localparam logic [3:0] OP_XNOR = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_SHR  = 4'd11;
  localparam logic [3:0] OP_ROL  = 4'd12;
  localparam logic [3:0] OP_ROR  = 4'd13;

  // One FIFO entry is {op, a, b}.
  localparam int CMD_W = 4 + 16 + 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAKE,
    ST_ISSUE,
    ST_WAIT_FIX,
    ST_WAIT_VALID,
    ST_RESP
  } seq_state_t;

  // MUL/DIV report completion through alu_valid; everything else is fixed latency.
  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, DEPTH x WIDTH, registered full/empty flags, async active-high reset.
// Latency: a push is visible at the head (empty=0) the cycle after it is written.
// Backpressure: pushes while full and pops while empty are ignored.
// Ports: clk, rst; push/wdata write side; pop/rdata read side (rdata = current head); full, empty.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_comb begin
    count_nxt = count + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count_nxt;
      // Flags are computed from the next count so they are plain flops.
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues buffered ALU commands one at a time (start pulse, then fixed wait or alu_valid wait) and returns results.
// Latency: non-MUL/DIV result FIX_LAT+1 cycles after alu_start; MUL/DIV on alu_valid or TIMEOUT abort; +1 WAKE cycle when gated.
// Backpressure: cmd_ready low while the FIFO is full; a response is held stable until rsp_ready, stalling further issue.
// Ports: cmd_* command stream in, rsp_* result stream out, busy status, alu_* ALU interface (en/start/op/a/b out, z/valid in).
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int FIX_LAT    = 2,
  parameter int TIMEOUT    = 64,
  parameter int GATE_DELAY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [3:0]  rsp_op,
  output logic [15:0] rsp_z_low,
  output logic [15:0] rsp_z_high,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        alu_en,
  output logic        alu_start,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_z_low,
  input  logic [15:0] alu_z_high,
  input  logic        alu_valid
);

  localparam int FW = $clog2(FIX_LAT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GATE_DELAY + 1);

  seq_state_t       state;
  logic [FW-1:0]    fix_cnt;
  logic [TW-1:0]    to_cnt;
  logic [GW-1:0]    gate_cnt;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic [CMD_W-1:0] fifo_head;
  logic [3:0]       head_op;
  logic [15:0]      head_a;
  logic [15:0]      head_b;
  logic             issue_next;

  // full is a flop inside the FIFO, so cmd_ready is registered.
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = (state == ST_ISSUE);
  assign {head_op, head_a, head_b} = fifo_head;
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  // The head is latched onto the ALU bus on entry to ISSUE, so alu_start is
  // high during the ISSUE cycle itself, the same cycle the head is popped.
  assign issue_next = ((state == ST_IDLE) && !fifo_empty && alu_en) ||
                      (state == ST_WAKE) ||
                      ((state == ST_RESP) && rsp_ready && !fifo_empty);

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({cmd_op, cmd_a, cmd_b}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      fix_cnt     <= '0;
      to_cnt      <= '0;
      gate_cnt    <= '0;
      alu_en      <= 1'b1;
      alu_start   <= 1'b0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      rsp_valid   <= 1'b0;
      rsp_op      <= '0;
      rsp_z_low   <= '0;
      rsp_z_high  <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      alu_start <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            gate_cnt <= '0;
            if (!alu_en) begin
              alu_en <= 1'b1;
              state  <= ST_WAKE;
            end else begin
              state  <= ST_ISSUE;
            end
          end else if (alu_en) begin
            if (gate_cnt == GW'(GATE_DELAY - 1)) begin
              alu_en   <= 1'b0;
              gate_cnt <= '0;
            end else begin
              gate_cnt <= gate_cnt + GW'(1);
            end
          end
        end

        ST_WAKE: state <= ST_ISSUE;

        ST_ISSUE: begin
          fix_cnt <= '0;
          to_cnt  <= '0;
          state   <= is_multicycle(alu_op) ? ST_WAIT_VALID : ST_WAIT_FIX;
        end

        ST_WAIT_FIX: begin
          if (fix_cnt == FW'(FIX_LAT - 1)) begin
            rsp_op      <= alu_op;
            rsp_z_low   <= alu_z_low;
            rsp_z_high  <= alu_z_high;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else begin
            fix_cnt <= fix_cnt + FW'(1);
          end
        end

        ST_WAIT_VALID: begin
          if (alu_valid) begin
            rsp_op      <= alu_op;
            rsp_z_low   <= alu_z_low;
            rsp_z_high  <= alu_z_high;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else if (to_cnt == TW'(TIMEOUT - 1)) begin
            rsp_op      <= alu_op;
            rsp_z_low   <= '0;
            rsp_z_high  <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else if (to_cnt != TW'(TIMEOUT)) begin
            to_cnt <= to_cnt + TW'(1);
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= fifo_empty ? ST_IDLE : ST_ISSUE;
          end
        end

        default: state <= ST_IDLE;
      endcase

      if (issue_next) begin
        alu_op    <= head_op;
        alu_a     <= head_a;
        alu_b     <= head_b;
        alu_start <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU behind it.
// Latency: ALU model returns fixed-latency results one cycle after start, MUL/DIV valid four cycles after start.
// Backpressure: rsp_ready is driven by the stimulus process to exercise response holding and FIFO full.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int DEPTH      = 4;
  localparam int FIX_LAT    = 2;
  localparam int TIMEOUT    = 64;
  localparam int GATE_DELAY = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b;
  logic        rsp_valid, rsp_ready;
  logic [3:0]  rsp_op;
  logic [15:0] rsp_z_low, rsp_z_high;
  logic        rsp_timeout, busy;
  logic        alu_en, alu_start;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic [15:0] alu_z_low, alu_z_high;
  logic        alu_valid;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .DEPTH(DEPTH), .FIX_LAT(FIX_LAT), .TIMEOUT(TIMEOUT), .GATE_DELAY(GATE_DELAY)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_z_low(rsp_z_low), .rsp_z_high(rsp_z_high), .rsp_timeout(rsp_timeout), .busy(busy),
    .alu_en(alu_en), .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_z_low(alu_z_low), .alu_z_high(alu_z_high), .alu_valid(alu_valid)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] zl;
    logic [15:0] zh;
    logic        to;
    int          lat;   // cycles from alu_start to rsp_valid, 0 = not checked
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- behavioural ALU ----------------
  logic        no_valid;
  logic [2:0]  mc_cnt;
  logic [31:0] pend;

  function automatic logic [31:0] alu_calc(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    logic [31:0] r;
    r = '0;
    case (op)
      OP_ADD: r = {16'h0, a + b};
      OP_SUB: r = {16'h0, a - b};
      OP_MUL: begin p = $signed(a) * $signed(b); r = p; end
      OP_DIV: if (b != 0) r = {a % b, a / b};
      OP_AND: r = {16'h0, a & b};
      OP_OR:  r = {16'h0, a | b};
      OP_XOR: r = {16'h0, a ^ b};
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_valid <= 1'b0;
      alu_z_low <= '0;
      alu_z_high <= '0;
      mc_cnt <= '0;
      pend <= '0;
    end else begin
      alu_valid <= 1'b0;
      if (mc_cnt != 0) begin
        mc_cnt <= mc_cnt - 3'd1;
        if (mc_cnt == 3'd1 && !no_valid) begin
          alu_valid <= 1'b1;
          {alu_z_high, alu_z_low} <= pend;
        end
      end
      if (alu_start && alu_en) begin
        if (is_multicycle(alu_op)) begin
          mc_cnt <= 3'd3;
          pend <= alu_calc(alu_op, alu_a, alu_b);
        end else begin
          {alu_z_high, alu_z_low} <= alu_calc(alu_op, alu_a, alu_b);
        end
      end
    end
  end

  // ---------------- monitor ----------------
  int   start_cnt, hs_cnt, start_cyc;
  logic prev_start;
  logic rsp_first;

  always @(negedge clk) begin
    if (rst) begin
      start_cnt = 0;
      hs_cnt = 0;
      prev_start = 1'b0;
      rsp_first = 1'b1;
    end else begin
      if (alu_start) begin
        check("start_single_cycle", prev_start, 0);
        check("start_after_prev_handshake", hs_cnt, start_cnt);
        start_cnt++;
        start_cyc = cyc;
      end
      prev_start = alu_start;
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_rsp: got op=%0h z=%h_%h, required no response", rsp_op, rsp_z_high, rsp_z_low);
        end else begin
          check("rsp_op", rsp_op, sb[0].op);
          check("rsp_z_low", rsp_z_low, sb[0].zl);
          check("rsp_z_high", rsp_z_high, sb[0].zh);
          check("rsp_timeout", rsp_timeout, sb[0].to);
          if (rsp_first && sb[0].lat != 0) check("rsp_latency", cyc - start_cyc, sb[0].lat);
          rsp_first = 1'b0;
          if (rsp_ready) begin
            void'(sb.pop_front());
            hs_cnt++;
            rsp_first = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] zl, input logic [15:0] zh, input logic to,
                      input int lat, input bit track);
    exp_t e;
    int n;
    if (track) begin
      e.op = op; e.zl = zl; e.zh = zh; e.to = to; e.lat = lat;
      sb.push_back(e);
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 200) begin
        n_vec++;
        n_miss++;
        $display("FAIL push_wait: cmd_ready stayed 0 for %0d cycles, required 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_wait: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_a = '0;
    cmd_b = '0;
    rsp_ready = 1'b1;
    no_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_alu_en", alu_en, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_alu_start", alu_start, 0);
    check("reset_busy", busy, 0);
    check("reset_alu_op", alu_op, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ADD 100+25
    push(OP_ADD, 16'd100, 16'd25, 16'h007D, 16'h0000, 1'b0, FIX_LAT + 1, 1'b1);
    wait_drain(200);

    // Back-to-back signed MULs
    push(OP_MUL, 16'd150, 16'd120, 16'h4650, 16'h0000, 1'b0, 0, 1'b1);
    push(OP_MUL, 16'hC568, 16'hD120, 16'h9500, 16'h0ABA, 1'b0, 0, 1'b1);
    wait_drain(200);

    // Fill the FIFO while the first response is held
    rsp_ready = 1'b0;
    push(OP_ADD, 16'd100, 16'd25,     16'h007D, 16'h0000, 1'b0, 0, 1'b1);
    push(OP_SUB, 16'd1000, 16'd1,     16'h03E7, 16'h0000, 1'b0, 0, 1'b1);
    push(OP_AND, 16'hF0F0, 16'h0FF0,  16'h00F0, 16'h0000, 1'b0, 0, 1'b1);
    push(OP_OR,  16'h1200, 16'h0034,  16'h1234, 16'h0000, 1'b0, 0, 1'b1);
    push(OP_XOR, 16'hFFFF, 16'h00FF,  16'hFF00, 16'h0000, 1'b0, 0, 1'b1);
    repeat (3) @(negedge clk);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_rsp_valid", rsp_valid, 1);
    check("full_busy", busy, 1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_drain(300);

    // DIV with an ALU that never completes
    no_valid = 1'b1;
    push(OP_DIV, 16'd100, 16'd3, 16'h0000, 16'h0000, 1'b1, TIMEOUT + 1, 1'b1);
    wait_drain(400);
    no_valid = 1'b0;

    // Clock gating and wake-up
    repeat (GATE_DELAY + 6) @(posedge clk);
    #1;
    check("gated_alu_en", alu_en, 0);
    check("gated_busy", busy, 0);
    push(OP_ADD, 16'd7, 16'd8, 16'h000F, 16'h0000, 1'b0, FIX_LAT + 1, 1'b1);
    n = 0;
    forever begin
      @(negedge clk);
      if (alu_en) break;
      n++;
      if (n > 20) begin
        n_vec++;
        n_miss++;
        $display("FAIL wake_wait: alu_en stayed 0, required 1");
        break;
      end
    end
    check("wake_no_start", alu_start, 0);
    @(negedge clk);
    check("start_after_wake", alu_start, 1);
    wait_drain(200);

    // Reset during a MUL's WAIT_VALID
    no_valid = 1'b1;
    push(OP_MUL, 16'd3, 16'd4, 16'h0, 16'h0, 1'b0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_start", alu_start, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_alu_en", alu_en, 1);
    check("rst_alu_op", alu_op, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    rst = 1'b0;
    no_valid = 1'b0;
    repeat (TIMEOUT + 10) @(posedge clk);
    #1;
    check("post_reset_no_rsp", rsp_valid, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
